// File: rtl/flappy_pkg.sv
// Shared constants, word-field positions and FSM state encoding for the flappy autopilot.
// The optional coin-chasing feature is enabled with AUTOPILOT_COIN_EN.
package flappy_pkg;

    localparam int BIRD_X   = 40;
    localparam int BIRD_H   = 16;
    localparam int PIPE_W   = 50;
    localparam int SCREEN_W = 640;

    localparam int PIPE_GAP_LSB = 20;
    localparam int PIPE_GAP_W   = 8;
    localparam int PIPE_X_LSB   = 10;
    localparam int PIPE_X_W     = 10;
    localparam int PIPE_Y_LSB   = 0;
    localparam int PIPE_Y_W     = 10;

    localparam int COIN_VALID_BIT = 31;
    localparam int COIN_Y_LSB     = 10;
    localparam int COIN_X_LSB     = 0;
    localparam int COIN_F_W       = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TRACK    = 3'd1,
        PRESS    = 3'd2,
        RELEASE  = 3'd3,
        COOLDOWN = 3'd4
    } ap_state_t;

endpackage

// File: rtl/flappy_target_sel.sv
// Combinational target picker: chooses the nearest pipe still ahead of the bird and
// derives the flap demand. Coin chasing is compiled in with AUTOPILOT_COIN_EN.
module flappy_target_sel
    import flappy_pkg::*;
#(
    parameter int MARGIN  = 6,
    parameter int FLOOR_Y = 240
) (
    input  logic [31:0] pipe1,
    input  logic [31:0] pipe2,
    input  logic [31:0] pipe3,
    input  logic [31:0] coin,
    input  logic [9:0]  by,
    input  logic        rising,
    output logic [1:0]  target_sel,
    output logic [10:0] tgt,
    output logic        demand
);

    logic [31:0] pipes [3];
    logic [31:0] sel_word;
    logic [10:0] px;
    logic [10:0] best_x;
    logic [10:0] gap_y;
    logic [10:0] half_gap;
    logic [10:0] sum;
    logic [10:0] pipe_tgt;

    assign pipes[0] = pipe1;
    assign pipes[1] = pipe2;
    assign pipes[2] = pipe3;

    always_comb begin
        target_sel = 2'd0;
        best_x     = '0;
        sel_word   = '0;
        px         = '0;
        // Strict less-than keeps the lowest index on an x tie.
        for (int i = 0; i < 3; i++) begin
            px = {1'b0, pipes[i][PIPE_X_LSB +: PIPE_X_W]};
            if ((px + 11'(PIPE_W) > 11'(BIRD_X)) && (target_sel == 2'd0 || px < best_x)) begin
                target_sel = 2'(i + 1);
                best_x     = px;
                sel_word   = pipes[i];
            end
        end
    end

    assign gap_y    = {1'b0, sel_word[PIPE_Y_LSB +: PIPE_Y_W]};
    assign half_gap = {3'b000, sel_word[PIPE_GAP_LSB +: PIPE_GAP_W] >> 1};
    assign sum      = gap_y + half_gap;
    assign pipe_tgt = (sum < 11'(BIRD_H / 2)) ? 11'd0 : sum - 11'(BIRD_H / 2);

`ifdef AUTOPILOT_COIN_EN
    logic [10:0] cx;
    logic [10:0] cy;
    logic        coin_valid;
    logic        unused_bits;

    assign cx          = {1'b0, coin[COIN_X_LSB +: COIN_F_W]};
    assign cy          = {1'b0, coin[COIN_Y_LSB +: COIN_F_W]};
    assign coin_valid  = coin[COIN_VALID_BIT];
    assign unused_bits = ^{coin[30:20], pipe1[31:28], pipe2[31:28], pipe3[31:28]};

    always_comb begin
        tgt = (target_sel == 2'd0) ? 11'(FLOOR_Y) : pipe_tgt;
        if (coin_valid && cx >= 11'(BIRD_X)) begin
            if (target_sel == 2'd0)
                tgt = cy;
            else if (cx < best_x && cy >= gap_y
                     && cy < gap_y + {3'b000, sel_word[PIPE_GAP_LSB +: PIPE_GAP_W]})
                tgt = cy;
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{coin, pipe1[31:28], pipe2[31:28], pipe3[31:28]};
    assign tgt         = (target_sel == 2'd0) ? 11'(FLOOR_Y) : pipe_tgt;
`endif

    assign demand = (({1'b0, by} + 11'(MARGIN)) < tgt) && !rising;

endmodule

// File: rtl/flappy_autopilot.sv
// Autopilot player: issues debounce-safe flap presses toward the selected pipe gap.
// Optional coin chasing in the target picker is enabled with AUTOPILOT_COIN_EN.
module flappy_autopilot
    import flappy_pkg::*;
#(
    parameter int MARGIN         = 6,
    parameter int PRESS_TICKS    = 2,
    parameter int RELEASE_TICKS  = 1,
    parameter int COOLDOWN_TICKS = 3,
    parameter int FLOOR_Y        = 240
) (
    input  logic        clk_100ms,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  status,
    input  logic [15:0] bird_y,
    input  logic [31:0] pipe1,
    input  logic [31:0] pipe2,
    input  logic [31:0] pipe3,
    input  logic [31:0] coin,
    output logic        up,
    output logic        pipe_up,
    output logic        pipe_down,
    output logic [1:0]  target_sel,
    output logic [7:0]  flap_cnt,
    output ap_state_t   state
);

    logic        active;
    logic [9:0]  by;
    logic [1:0]  sel_next;
    logic [10:0] tgt;
    logic        demand;
    logic [7:0]  cnt;
    logic [8:0]  cnt_inc;

    assign active    = enable && (status == 2'd0 || status == 2'd3);
    // A bird wrapped below the floor sits at y=0 so it always demands a flap.
    assign by        = (bird_y[14:10] != 5'd0) ? 10'd0 : bird_y[9:0];
    assign cnt_inc   = {1'b0, cnt} + 9'd1;
    assign pipe_up   = 1'b0;
    assign pipe_down = 1'b0;

    flappy_target_sel #(
        .MARGIN  (MARGIN),
        .FLOOR_Y (FLOOR_Y)
    ) u_sel (
        .pipe1      (pipe1),
        .pipe2      (pipe2),
        .pipe3      (pipe3),
        .coin       (coin),
        .by         (by),
        .rising     (bird_y[15]),
        .target_sel (sel_next),
        .tgt        (tgt),
        .demand     (demand)
    );

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            up         <= 1'b0;
            cnt        <= '0;
            flap_cnt   <= '0;
            target_sel <= 2'd0;
        end else begin
            if (active)
                target_sel <= sel_next;
            if (!active) begin
                state <= IDLE;
                up    <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        up    <= 1'b0;
                        cnt   <= '0;
                        state <= TRACK;
                    end
                    TRACK: begin
                        if (demand) begin
                            up    <= 1'b1;
                            cnt   <= '0;
                            state <= PRESS;
                            if (flap_cnt != 8'hFF)
                                flap_cnt <= flap_cnt + 8'd1;
                        end
                    end
                    // Once started, a press runs its full length regardless of demand.
                    PRESS: begin
                        if (cnt_inc >= 9'(PRESS_TICKS)) begin
                            up    <= 1'b0;
                            cnt   <= '0;
                            state <= RELEASE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    RELEASE: begin
                        if (cnt_inc >= 9'(RELEASE_TICKS)) begin
                            cnt   <= '0;
                            state <= (COOLDOWN_TICKS == 0) ? TRACK : COOLDOWN;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    COOLDOWN: begin
                        if (cnt_inc >= 9'(COOLDOWN_TICKS)) begin
                            cnt   <= '0;
                            state <= TRACK;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: begin
                        up    <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flappy_autopilot.sv
// Directed bench for flappy_autopilot: press timing, dead-band, target choice,
// abort, saturation and asynchronous reset.
module tb_flappy_autopilot;
    import flappy_pkg::*;

    logic        clk_100ms = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  status;
    logic [15:0] bird_y;
    logic [31:0] pipe1, pipe2, pipe3, coin;
    logic        up, pipe_up, pipe_down;
    logic [1:0]  target_sel;
    logic [7:0]  flap_cnt;
    ap_state_t   state;

    int total = 0;
    int bad   = 0;

    flappy_autopilot dut (
        .clk_100ms  (clk_100ms),
        .rst        (rst),
        .enable     (enable),
        .status     (status),
        .bird_y     (bird_y),
        .pipe1      (pipe1),
        .pipe2      (pipe2),
        .pipe3      (pipe3),
        .coin       (coin),
        .up         (up),
        .pipe_up    (pipe_up),
        .pipe_down  (pipe_down),
        .target_sel (target_sel),
        .flap_cnt   (flap_cnt),
        .state      (state)
    );

    always #5 clk_100ms = ~clk_100ms;

    function automatic logic [31:0] mk_pipe(input int gap, input int x, input int y);
        logic [7:0] g;
        logic [9:0] xx;
        logic [9:0] yy;
        g  = 8'(gap);
        xx = 10'(x);
        yy = 10'(y);
        return {4'h0, g, xx, yy};
    endfunction

    task automatic tick();
        @(posedge clk_100ms);
        #1;
    endtask

    task automatic set_default_pipes();
        pipe1 = mk_pipe(120, 200, 150);
        pipe2 = mk_pipe(120, 400, 150);
        pipe3 = mk_pipe(120, 600, 150);
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; status = 2'd0; bird_y = '0; coin = '0;
        set_default_pipes();
        #23;
        total++; if (up !== 1'b0 || flap_cnt !== 8'd0 || target_sel !== 2'd0) begin
            bad++; $display("FAIL reset_hold: up=%0d flap=%0d sel=%0d want 0/0/0", up, flap_cnt, target_sel);
        end
        rst = 1'b1;
        repeat (5) tick();
        total++; if (up !== 1'b0 || flap_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_idle_out: up=%0d flap=%0d want 0/0", up, flap_cnt);
        end
        total++; if (state !== IDLE) begin
            bad++; $display("FAIL reset_state: got %0d want %0d", state, IDLE);
        end
        total++; if (pipe_up !== 1'b0 || pipe_down !== 1'b0 || target_sel !== 2'd0) begin
            bad++; $display("FAIL reset_aux: pu=%0d pd=%0d sel=%0d want 0", pipe_up, pipe_down, target_sel);
        end
    endtask

    task automatic test_low_bird();
        enable = 1'b1; status = 2'd0; bird_y = 16'd100;
        tick();
        total++; if (state !== TRACK || target_sel !== 2'd1 || up !== 1'b0) begin
            bad++; $display("FAIL low_track: st=%0d sel=%0d up=%0d want %0d/1/0", state, target_sel, up, TRACK);
        end
        total++; if (dut.u_sel.tgt !== 11'd202) begin
            bad++; $display("FAIL low_tgt: got %0d want 202", dut.u_sel.tgt);
        end
        tick();
        total++; if (up !== 1'b1 || flap_cnt !== 8'd1 || state !== PRESS) begin
            bad++; $display("FAIL low_press1: up=%0d flap=%0d st=%0d want 1/1/%0d", up, flap_cnt, state, PRESS);
        end
        tick();
        total++; if (up !== 1'b1) begin
            bad++; $display("FAIL low_press2: up=%0d want 1", up);
        end
        tick();
        total++; if (up !== 1'b0 || state !== RELEASE) begin
            bad++; $display("FAIL low_release: up=%0d st=%0d want 0/%0d", up, state, RELEASE);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (up !== 1'b0 || state !== COOLDOWN) begin
                bad++; $display("FAIL low_cooldown%0d: up=%0d st=%0d want 0/%0d", i, up, state, COOLDOWN);
            end
        end
        tick();
        total++; if (up !== 1'b0 || state !== TRACK) begin
            bad++; $display("FAIL low_retrack: up=%0d st=%0d want 0/%0d", up, state, TRACK);
        end
        tick();
        total++; if (up !== 1'b1 || flap_cnt !== 8'd2) begin
            bad++; $display("FAIL low_second_flap: up=%0d flap=%0d want 1/2", up, flap_cnt);
        end
    endtask

    task automatic test_status_gate();
        enable = 1'b0; tick();
        status = 2'd1; bird_y = 16'd100; enable = 1'b1;
        repeat (3) tick();
        total++; if (up !== 1'b0 || state !== IDLE || flap_cnt !== 8'd2) begin
            bad++; $display("FAIL status_gate: up=%0d st=%0d flap=%0d want 0/%0d/2", up, state, flap_cnt, IDLE);
        end
    endtask

    task automatic test_dead_band();
        enable = 1'b0; tick();
        status = 2'd3; bird_y = 16'd198; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (up !== 1'b0) begin
                bad++; $display("FAIL dead_band_t%0d: up=%0d want 0", i, up);
            end
        end
        total++; if (flap_cnt !== 8'd2 || state !== TRACK) begin
            bad++; $display("FAIL dead_band_end: flap=%0d st=%0d want 2/%0d", flap_cnt, state, TRACK);
        end
    endtask

    task automatic test_rising();
        enable = 1'b0; tick();
        status = 2'd0; bird_y = 16'h8064; enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (up !== 1'b0) begin
                bad++; $display("FAIL rising_t%0d: up=%0d want 0", i, up);
            end
        end
        bird_y = 16'h0064;
        tick();
        total++; if (up !== 1'b1 || flap_cnt !== 8'd3) begin
            bad++; $display("FAIL rising_clear: up=%0d flap=%0d want 1/3", up, flap_cnt);
        end
    endtask

    task automatic test_press_integrity();
        enable = 1'b0; tick();
        bird_y = 16'd100; enable = 1'b1;
        tick(); tick();
        total++; if (up !== 1'b1 || flap_cnt !== 8'd4) begin
            bad++; $display("FAIL integ_start: up=%0d flap=%0d want 1/4", up, flap_cnt);
        end
        bird_y = 16'd198;
        tick();
        total++; if (up !== 1'b1 || state !== PRESS) begin
            bad++; $display("FAIL integ_hold: up=%0d st=%0d want 1/%0d", up, state, PRESS);
        end
        tick();
        total++; if (up !== 1'b0 || state !== RELEASE) begin
            bad++; $display("FAIL integ_end: up=%0d st=%0d want 0/%0d", up, state, RELEASE);
        end
    endtask

    task automatic test_pass_tie();
        enable = 1'b0; tick();
        bird_y = 16'd198;
        pipe1 = mk_pipe(120, 0, 150);
        pipe2 = mk_pipe(120, 300, 150);
        pipe3 = mk_pipe(120, 300, 150);
        enable = 1'b1;
        tick();
        total++; if (target_sel !== 2'd1) begin
            bad++; $display("FAIL pass_x0: sel=%0d want 1", target_sel);
        end
        pipe1 = mk_pipe(120, 640, 150);
        tick();
        total++; if (target_sel !== 2'd2) begin
            bad++; $display("FAIL tie_sel: sel=%0d want 2", target_sel);
        end
        enable = 1'b0;
        pipe2 = mk_pipe(120, 700, 150);
        tick();
        total++; if (target_sel !== 2'd2) begin
            bad++; $display("FAIL sel_hold: sel=%0d want 2", target_sel);
        end
        enable = 1'b1;
        tick();
        total++; if (target_sel !== 2'd3) begin
            bad++; $display("FAIL sel_resume: sel=%0d want 3", target_sel);
        end
        set_default_pipes();
    endtask

    task automatic test_underflow_abort();
        enable = 1'b0; tick();
        bird_y = 16'h7FF0; enable = 1'b1;
        tick();
        total++; if (state !== TRACK) begin
            bad++; $display("FAIL uf_track: st=%0d want %0d", state, TRACK);
        end
        tick();
        total++; if (up !== 1'b1 || flap_cnt !== 8'd5) begin
            bad++; $display("FAIL uf_press: up=%0d flap=%0d want 1/5", up, flap_cnt);
        end
        enable = 1'b0;
        tick();
        total++; if (up !== 1'b0 || state !== IDLE || flap_cnt !== 8'd5) begin
            bad++; $display("FAIL abort: up=%0d st=%0d flap=%0d want 0/%0d/5", up, state, flap_cnt, IDLE);
        end
    endtask

    task automatic test_saturation();
        bird_y = 16'd0; enable = 1'b1;
        for (int i = 1; i <= 2200; i++) begin
            tick();
            if (i == 702) begin
                total++; if (flap_cnt !== 8'd106) begin
                    bad++; $display("FAIL sat_mid: flap=%0d want 106", flap_cnt);
                end
            end
            if (i == 1744) begin
                total++; if (flap_cnt !== 8'd254) begin
                    bad++; $display("FAIL sat_pre: flap=%0d want 254", flap_cnt);
                end
            end
            if (i == 1745) begin
                total++; if (flap_cnt !== 8'd255) begin
                    bad++; $display("FAIL sat_hit: flap=%0d want 255", flap_cnt);
                end
            end
        end
        total++; if (flap_cnt !== 8'd255) begin
            bad++; $display("FAIL sat_hold: flap=%0d want 255", flap_cnt);
        end
    endtask

    task automatic test_async_reset();
        enable = 1'b0; tick();
        bird_y = 16'd100; enable = 1'b1;
        tick(); tick();
        total++; if (up !== 1'b1) begin
            bad++; $display("FAIL ar_pre: up=%0d want 1", up);
        end
        #2 rst = 1'b0;
        #1;
        total++; if (up !== 1'b0 || flap_cnt !== 8'd0 || state !== IDLE || target_sel !== 2'd0) begin
            bad++; $display("FAIL ar_now: up=%0d flap=%0d st=%0d sel=%0d want 0/0/%0d/0", up, flap_cnt, state, target_sel, IDLE);
        end
        enable = 1'b0;
        #1 rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_low_bird();
        test_status_gate();
        test_dead_band();
        test_rising();
        test_press_integrity();
        test_pass_tie();
        test_underflow_abort();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flappy_autopilot.md
Name: flappy_autopilot

Overview:
- Autonomous player for the flappy game core.
- Consumes the packed game-state words the control block publishes: status, bird_y, pipe1..pipe3, and optionally coin.
- Drives the up, pipe_up and pipe_down button inputs with press/release patterns that survive the core's debouncers and long-press lock.
- Sits between the control block outputs and a 2:1 mux in front of the control block's button inputs; used for attract/demo mode and single-player bench runs.

Parameters:
BIRD_X, 40, fixed bird left-edge x coordinate
BIRD_H, 16, bird height in pixels
PIPE_W, 50, pipe width in pixels
MARGIN, 6, dead-band below the target y before a flap is issued
PRESS_TICKS, 2, clk_100ms ticks that up is held high per flap
RELEASE_TICKS, 1, minimum ticks up is held low after a press
COOLDOWN_TICKS, 3, ticks after release before the next flap decision
FLOOR_Y, 240, target y used when no pipe is ahead

Ports:
clk_100ms  in   1   game tick clock
rst        in   1   reset, asynchronous, active-low
enable     in   1   autopilot armed; 0 forces all button outputs low
status     in   2   game status from the control block (0 single, 3 versus, 1/2 transient)
bird_y     in   16  [15] rising flag, [14:0] bird bottom y; y grows upward
pipe1      in   32  [27:20] gap, [19:10] left x, [9:0] lower gap edge y; [31:28] ignored
pipe2      in   32  same layout as pipe1
pipe3      in   32  same layout as pipe1
coin       in   32  [31] valid, [19:10] y, [9:0] x
up         out  1   flap button
pipe_up    out  1   tied 0 in this block; reserved for the versus bot
pipe_down  out  1   tied 0
target_sel out  2   selected pipe: 1..3, or 0 for none
flap_cnt   out  8   flaps issued since reset, saturating at 255

Behaviour:
- Reset (rst=0, asynchronous): up=0, pipe_up=0, pipe_down=0, target_sel=0, flap_cnt=0, state=IDLE, all counters 0.
- All outputs are registered; each reflects inputs sampled on the previous tick, giving 1 tick of latency.
- Active condition: active = enable && (status==0 || status==3).
- Target selection, combinational on current inputs:
  - A pipe is ahead when x+PIPE_W > BIRD_X, computed in 11 bits.
  - Among pipes that are ahead, the smallest x wins.
  - On an x tie, the lowest index wins.
  - If no pipe is ahead, target_sel=0 and tgt=FLOOR_Y.
  - Otherwise tgt = y + (gap>>1) - (BIRD_H>>1), in 11 bits, clamped to a minimum of 0.
- Bird position: by = bird_y[9:0].
- Underflow: if bird_y[14:10]!=0, the bird has wrapped below the floor; treat by as 0, which forces demand.
- demand = (by + MARGIN < tgt) && !bird_y[15].
- FSM states and transitions:
  - IDLE: up=0. Go to TRACK when active.
  - TRACK: when demand, set up=1, reset the counter, increment flap_cnt (saturating at 255), go to PRESS.
  - PRESS: hold up=1 for PRESS_TICKS ticks, then up=0 and go to RELEASE.
  - RELEASE: hold up=0 for RELEASE_TICKS ticks, then go to COOLDOWN.
  - COOLDOWN: wait COOLDOWN_TICKS ticks, then go to TRACK. With COOLDOWN_TICKS=0, go straight to TRACK.
- Dropping active in any state: on the next tick, go to IDLE with up=0.
- Press integrity: a PRESS begun while active is never cut short by a demand change. A press is cut short only by active falling or by reset.
- Counters are 8 bits wide; parameters above 255 are illegal.
- target_sel updates every tick, in any state, whenever active; it is held while inactive.

Optional Feature:
AUTOPILOT_COIN_EN
- Defined:
  - When coin[31]=1, coin x lies in [BIRD_X, selected pipe x), and coin y lies inside the selected pipe's gap, then tgt = coin y.
  - When no pipe is ahead, a valid coin with x>=BIRD_X sets tgt = coin y.
  - Otherwise the pipe target is used.
- Undefined: the coin port is unused and the pipe rule alone applies.

Decomposition:
- Package flappy_pkg holds:
  - constants BIRD_X, BIRD_H, PIPE_W, SCREEN_W=640;
  - field-slice localparams for the pipe word (gap, x, y) and the coin word (valid, y, x);
  - the FSM state enum {IDLE, TRACK, PRESS, RELEASE, COOLDOWN}.
- Sub-module flappy_target_sel is combinational. It takes pipe1..3, coin and by, and returns target_sel, tgt and demand.

Test Plan:
- Reset: rst=0 then release, enable=0 for 5 ticks -> up=0, flap_cnt=0, state IDLE.
- Low bird: enable=1, status=0, bird_y=100, pipe1={gap 120, x 200, y 150}, pipe2/pipe3 at x 400/600.
  - Expected: target_sel=1, tgt=202.
  - up high for exactly 2 ticks, low for 1 tick, no press for 3 ticks.
  - flap_cnt=1 after the first flap.
- Dead-band: bird_y=198, same pipes -> by+6=204 >= 202, so up stays 0 for 10 ticks.
- Rising-flag suppression: bird_y=16'h8064 -> no press while bit15=1.
  - Clear bit15 -> press begins 1 tick later.
- Pass-over and tie: pipe1 x=0, pipe2 x=300, pipe3 x=300 -> target_sel=1, since 0+50>40.
  - Set pipe1 x=640 -> target_sel=2.
- Underflow and mid-press abort:
  - bird_y=16'h7FF0 -> demand, up=1.
  - Drop enable during PRESS -> up=0 next tick, IDLE.
  - flap_cnt is not decremented.
- Saturation: force 300 flaps -> flap_cnt holds at 255.
